// File: rtl/jtag_tap_sync.sv
// Clock-synchronous IEEE 1149.1 TAP responder: oversamples the JTAG pins with clk_i
// and serves IDCODE, BYPASS and a CONFREG configuration register.
module jtag_tap_sync #(
  parameter logic [31:0] IDCODE_VALUE = 32'h249511C3,
  parameter int unsigned IR_LEN       = 5,
  parameter int unsigned CONFREG_W    = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 jtag_tck_i,
  input  logic                 jtag_trst_ni,
  input  logic                 jtag_tms_i,
  input  logic                 jtag_tdi_i,
  output logic                 jtag_tdo_o,
  output logic                 jtag_tdo_en_o,
  output logic [3:0]           tap_state_o,
  output logic [IR_LEN-1:0]    ir_o,
  output logic [CONFREG_W-1:0] conf_reg_o,
  output logic                 conf_update_o
);

  localparam int unsigned DR_W = 32;

  localparam logic [IR_LEN-1:0] INSTR_IDCODE  = IR_LEN'(5'b00001);
  localparam logic [IR_LEN-1:0] INSTR_CONFREG = IR_LEN'(5'b00110);

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  // 1149.1 state transition on a TCK rising edge
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TLR;
    case (s)
      TLR:      n = tms ? TLR      : RTI;
      RTI:      n = tms ? SEL_DR   : RTI;
      SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   n = tms ? EX1_DR   : SH_DR;
      SH_DR:    n = tms ? EX1_DR   : SH_DR;
      EX1_DR:   n = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   n = tms ? UPD_DR   : SH_DR;
      UPD_DR:   n = tms ? SEL_DR   : RTI;
      SEL_IR:   n = tms ? TLR      : CAP_IR;
      CAP_IR:   n = tms ? EX1_IR   : SH_IR;
      SH_IR:    n = tms ? EX1_IR   : SH_IR;
      EX1_IR:   n = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   n = tms ? UPD_IR   : SH_IR;
      UPD_IR:   n = tms ? SEL_DR   : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

  logic [2:0] tck_q;
  logic [1:0] tms_q;
  logic [1:0] tdi_q;
  logic [1:0] trst_q;

  // Pin synchronizers are deliberately not reset, so a TCK edge in flight is not replayed after rst_i
  always_ff @(posedge clk_i) begin
    tck_q  <= {tck_q[1:0], jtag_tck_i};
    tms_q  <= {tms_q[0], jtag_tms_i};
    tdi_q  <= {tdi_q[0], jtag_tdi_i};
    trst_q <= {trst_q[0], jtag_trst_ni};
  end

  logic tck_rise;
  logic tck_fall;
  logic tms_s;
  logic tdi_s;
  logic trst_s;

  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms_s    = tms_q[1];
  assign tdi_s    = tdi_q[1];
  assign trst_s   = trst_q[1];

  tap_state_e        state;
  logic [IR_LEN-1:0] ir_sr;
  logic [DR_W-1:0]   dr_sr;
  logic              sel_idcode;
  logic              sel_conf;

  assign sel_idcode = (ir_o == INSTR_IDCODE);
  assign sel_conf   = (ir_o == INSTR_CONFREG);

  assign tap_state_o   = state;
  assign jtag_tdo_en_o = (state == SH_IR) || (state == SH_DR);

  // TAP controller, instruction/data shift paths and TDO launch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= TLR;
      ir_sr         <= '0;
      dr_sr         <= '0;
      ir_o          <= INSTR_IDCODE;
      conf_reg_o    <= '0;
      conf_update_o <= 1'b0;
      jtag_tdo_o    <= 1'b0;
    end else begin
      conf_update_o <= 1'b0;
      if (!trst_s) begin
        state <= TLR;
        ir_o  <= INSTR_IDCODE;
      end else begin
        if (state == TLR) begin
          ir_o <= INSTR_IDCODE;
        end
        if (tck_rise) begin
          state <= tap_next(state, tms_s);
          case (state)
            CAP_IR: ir_sr <= IR_LEN'(1);
            SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
            EX1_IR, EX2_IR: begin
              if (tms_s) ir_o <= ir_sr;
            end
            CAP_DR: begin
              if (sel_idcode)    dr_sr <= IDCODE_VALUE;
              else if (sel_conf) dr_sr <= DR_W'(conf_reg_o);
              else               dr_sr <= '0;
            end
            SH_DR: begin
              if (sel_idcode)    dr_sr <= {tdi_s, dr_sr[DR_W-1:1]};
              else if (sel_conf) dr_sr[CONFREG_W-1:0] <= {tdi_s, dr_sr[CONFREG_W-1:1]};
              else               dr_sr[0] <= tdi_s;
            end
            EX1_DR, EX2_DR: begin
              if (tms_s && sel_conf) begin
                conf_reg_o    <= dr_sr[CONFREG_W-1:0];
                conf_update_o <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (tck_fall) begin
          if (state == SH_IR)      jtag_tdo_o <= ir_sr[0];
          else if (state == SH_DR) jtag_tdo_o <= dr_sr[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Directed bench for jtag_tap_sync: a table walk of the TAP state graph plus
// hand-written IDCODE, BYPASS, CONFREG, TRST, pause and reset-collision sequences.
module tb_jtag_tap_sync;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       jtag_tck_i;
  logic       jtag_trst_ni;
  logic       jtag_tms_i;
  logic       jtag_tdi_i;
  logic       jtag_tdo_o;
  logic       jtag_tdo_en_o;
  logic [3:0] tap_state_o;
  logic [4:0] ir_o;
  logic [8:0] conf_reg_o;
  logic       conf_update_o;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  always #5 clk_i = ~clk_i;

  jtag_tap_sync dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .jtag_tck_i    (jtag_tck_i),
    .jtag_trst_ni  (jtag_trst_ni),
    .jtag_tms_i    (jtag_tms_i),
    .jtag_tdi_i    (jtag_tdi_i),
    .jtag_tdo_o    (jtag_tdo_o),
    .jtag_tdo_en_o (jtag_tdo_en_o),
    .tap_state_o   (tap_state_o),
    .ir_o          (ir_o),
    .conf_reg_o    (conf_reg_o),
    .conf_update_o (conf_update_o)
  );

  always @(negedge clk_i) begin
    if (conf_update_o) upd_cnt++;
  end

  typedef struct {
    logic       tms;
    logic [3:0] st;
    logic       en;
  } step_t;

  step_t walk [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full TCK period: 6 clk low with tms/tdi set, 6 clk high, 6 clk low settle
  task automatic tck(input logic tms, input logic tdi);
    jtag_tms_i = tms;
    jtag_tdi_i = tdi;
    repeat (6) @(negedge clk_i);
    jtag_tck_i = 1'b1;
    repeat (6) @(negedge clk_i);
    jtag_tck_i = 1'b0;
    repeat (6) @(negedge clk_i);
  endtask

  // RTI -> Shift-IR -> Update-IR -> RTI
  task automatic scan_ir(input logic [4:0] v, output logic [4:0] o);
    o = '0;
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      o[i] = jtag_tdo_o;
      tck(i == 4, v[i]);
    end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  // RTI -> Shift-DR (n bits) -> Update-DR -> RTI
  task automatic scan_dr(input logic [31:0] v, input int n, output logic [31:0] o);
    o = '0;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      o[i] = jtag_tdo_o;
      tck(i == n - 1, v[i]);
    end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0]  ir_out;
    logic [31:0] dr_out;
    logic [8:0]  pv;
    int          u0;

    walk = '{
      '{1'b0, 4'hC, 1'b0}, '{1'b1, 4'h7, 1'b0}, '{1'b0, 4'h6, 1'b0}, '{1'b0, 4'h2, 1'b1},
      '{1'b1, 4'h1, 1'b0}, '{1'b0, 4'h3, 1'b0}, '{1'b1, 4'h0, 1'b0}, '{1'b1, 4'h5, 1'b0},
      '{1'b1, 4'h7, 1'b0}, '{1'b1, 4'h4, 1'b0}, '{1'b0, 4'hE, 1'b0}, '{1'b0, 4'hA, 1'b1},
      '{1'b1, 4'h9, 1'b0}, '{1'b0, 4'hB, 1'b0}, '{1'b1, 4'h8, 1'b0}, '{1'b0, 4'hA, 1'b1},
      '{1'b1, 4'h9, 1'b0}, '{1'b1, 4'hD, 1'b0}, '{1'b0, 4'hC, 1'b0}, '{1'b1, 4'h7, 1'b0},
      '{1'b1, 4'h4, 1'b0}, '{1'b1, 4'hF, 1'b0}
    };

    rst_i        = 1'b1;
    jtag_tck_i   = 1'b0;
    jtag_trst_ni = 1'b1;
    jtag_tms_i   = 1'b1;
    jtag_tdi_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    check("rst_state", 32'(tap_state_o), 32'hF);
    check("rst_ir", 32'(ir_o), 32'h01);
    check("rst_tdo", 32'(jtag_tdo_o), 32'h0);
    check("rst_tdo_en", 32'(jtag_tdo_en_o), 32'h0);
    check("rst_conf", 32'(conf_reg_o), 32'h0);
    check("rst_upd", 32'(conf_update_o), 32'h0);

    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    check("tms5_state", 32'(tap_state_o), 32'hF);
    check("tms5_ir", 32'(ir_o), 32'h01);

    for (int i = 0; i < 22; i++) begin
      tck(walk[i].tms, 1'b0);
      check($sformatf("walk%0d_state", i), 32'(tap_state_o), 32'(walk[i].st));
      check($sformatf("walk%0d_tdo_en", i), 32'(jtag_tdo_en_o), 32'(walk[i].en));
    end
    check("walk_end_ir", 32'(ir_o), 32'h01);

    // IDCODE read straight out of TLR
    tck(1'b0, 1'b0);
    scan_dr(32'h0, 32, dr_out);
    check("idcode", dr_out, 32'h249511C3);
    check("idcode_state", 32'(tap_state_o), 32'hC);

    // IR capture pattern, then BYPASS one-bit delay
    scan_ir(5'b11111, ir_out);
    check("ir_capture", 32'(ir_out), 32'h01);
    check("ir_bypass", 32'(ir_o), 32'h1F);
    scan_dr(32'b1101, 4, dr_out);
    check("bypass_tdo", dr_out & 32'hF, 32'b1010);

    // CONFREG write then readback
    scan_ir(5'b00110, ir_out);
    check("ir_conf", 32'(ir_o), 32'h06);
    u0 = upd_cnt;
    scan_dr(32'h002, 9, dr_out);
    check("conf_first_tdo", dr_out & 32'h1FF, 32'h000);
    check("conf_write1", 32'(conf_reg_o), 32'h002);
    check("conf_upd_pulses1", 32'(upd_cnt - u0), 32'd1);
    u0 = upd_cnt;
    scan_dr(32'h1FF, 9, dr_out);
    check("conf_readback", dr_out & 32'h1FF, 32'h002);
    check("conf_write2", 32'(conf_reg_o), 32'h1FF);
    check("conf_upd_pulses2", 32'(upd_cnt - u0), 32'd1);

    // TRST mid-shift abandons the scan
    u0 = upd_cnt;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tck(1'b0, 1'b0);
    check("pre_trst_state", 32'(tap_state_o), 32'h2);
    jtag_trst_ni = 1'b0;
    repeat (4) @(negedge clk_i);
    jtag_trst_ni = 1'b1;
    repeat (6) @(negedge clk_i);
    check("trst_state", 32'(tap_state_o), 32'hF);
    check("trst_ir", 32'(ir_o), 32'h01);
    check("trst_conf", 32'(conf_reg_o), 32'h1FF);
    check("trst_upd", 32'(upd_cnt - u0), 32'd0);

    // CONFREG shift interrupted by ten TCKs in Pause-DR
    tck(1'b0, 1'b0);
    scan_ir(5'b00110, ir_out);
    pv = 9'h0A5;
    u0 = upd_cnt;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tck(i == 4, pv[i]);
    check("pause_ex1", 32'(tap_state_o), 32'h1);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck(1'b0, 1'b1);
    check("pause_hold", 32'(tap_state_o), 32'h3);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    check("pause_resume", 32'(tap_state_o), 32'h2);
    for (int i = 5; i < 9; i++) tck(i == 8, pv[i]);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    check("pause_conf", 32'(conf_reg_o), 32'h0A5);
    check("pause_upd", 32'(upd_cnt - u0), 32'd1);

    // Five TMS=1 from Pause-IR reaches TLR
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    check("pause_ir", 32'(tap_state_o), 32'hB);
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    check("tms5b_state", 32'(tap_state_o), 32'hF);
    check("tms5b_ir", 32'(ir_o), 32'h01);

    // rst_i coinciding with tck_rise drops the edge and clears conf_reg_o
    jtag_tms_i = 1'b0;
    repeat (6) @(negedge clk_i);
    jtag_tck_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    jtag_tck_i = 1'b0;
    repeat (6) @(negedge clk_i);
    check("collide_state", 32'(tap_state_o), 32'hF);
    check("collide_conf", 32'(conf_reg_o), 32'h0);
    check("collide_ir", 32'(ir_o), 32'h01);
    tck(1'b0, 1'b0);
    check("post_collide_state", 32'(tap_state_o), 32'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sync.md
# jtag_tap_sync

Clock-synchronous IEEE 1149.1 TAP responder for the JTAG-to-L2 test path. Oversamples the external JTAG pins with the system clock, runs the 16-state TAP controller, and serves IDCODE, BYPASS and a 9-bit configuration register (CONFREG) that drives the test-mode/stimulus-source selection. It is the target end of the host-side JTAG sequences (reset, soft reset, IDCODE read, confreg set).

## Interface
- IDCODE_VALUE, 32'h249511C3, value captured in Capture-DR under IDCODE; bit 0 must be 1
- IR_LEN, 5, instruction register length
- CONFREG_W, 9, configuration register width
- clk_i  in  1  system clock, samples all JTAG pins
- rst_i  in  1  synchronous, active-high reset
- jtag_tck_i  in  1  JTAG clock, asynchronous to clk_i
- jtag_trst_ni  in  1  JTAG reset, active low, sampled
- jtag_tms_i  in  1  test mode select
- jtag_tdi_i  in  1  test data in
- jtag_tdo_o  out  1  test data out
- jtag_tdo_en_o  out  1  high while in Shift-IR or Shift-DR
- tap_state_o  out  4  current TAP state code
- ir_o  out  IR_LEN  active instruction
- conf_reg_o  out  CONFREG_W  configuration register
- conf_update_o  out  1  one-cycle pulse when conf_reg_o is written

## Operation
- Pin sampling: tck, tms, tdi and trst_n each pass through a 2-flop synchronizer. A third tck flop gives tck_rise = s & ~d and tck_fall = ~s & d.
- TAP FSM advances only on tck_rise, using synchronized tms. State codes: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D. Transitions follow 1149.1.
- Instructions: IDCODE=5'b00001, CONFREG=5'b00110, BYPASS=5'b11111. Any other code selects BYPASS.
- IR path:
  - CapIR loads 5'b00001 into the IR shift register.
  - ShIR shifts right, LSB first out, tdi into the MSB.
  - UpdIR copies the shift register to ir_o.
  - TLR forces ir_o = IDCODE.
- DR path, selected by ir_o:
  - CapDR loads IDCODE_VALUE, 1'b0 (BYPASS), or conf_reg_o (CONFREG).
  - ShDR shifts right with tdi into the MSB of the selected register.
  - UpdDR under CONFREG writes the shift register to conf_reg_o and pulses conf_update_o.
- TDO: on tck_fall, jtag_tdo_o is loaded with the LSB of the active shift register if the state is ShIR or ShDR; otherwise it holds its value. jtag_tdo_en_o is combinational from state.
- TAP reset sources:
  - rst_i: state=TLR and all outputs reset.
  - Synchronized trst_n low: state=TLR and ir_o=IDCODE; conf_reg_o is NOT cleared.
  - Five tck_rise with tms=1: reaches TLR from any state through normal FSM transitions.
- conf_reg_o is cleared only by rst_i.

## Timing
- Reset values: jtag_tdo_o=0, jtag_tdo_en_o=0, tap_state_o=4'hF, ir_o=5'b00001, conf_reg_o=0, conf_update_o=0. All shift registers are 0.
- Latency from a TCK rising pin edge to the state/shift update: 3 clk_i cycles (2 sync + 1 register).
- Latency from a TCK falling pin edge to a jtag_tdo_o change: 3 clk_i cycles.
- Requirement: TCK high and low phases each ≥ 4 clk_i periods. TMS/TDI must be stable ≥ 3 clk_i periods around the TCK rising edge. Behaviour outside these limits is undefined.
- conf_update_o is high for exactly 1 clk_i cycle, in the cycle after the FSM enters UpdDR.
- Simultaneous rst_i and tck_rise: rst_i wins and the edge is dropped.
- trst_n low mid-shift: the shift is abandoned and no update happens.
- rst_i mid-operation: everything returns to reset values on the next clk_i edge.
- Leaving ShDR through Ex1DR→PauseDR→Ex2DR→ShDR keeps the shift-register contents intact.

## Test plan
- Reset: rst_i high for 2 cycles, then TMS=1 for 5 TCKs → tap_state_o=F, ir_o=5'b00001, jtag_tdo_o=0, conf_reg_o=0.
- IDCODE read: from TLR, go to ShDR and shift 32 bits → TDO stream LSB-first equals 32'h249511C3.
- IR capture and BYPASS:
  - Shift IR 5'b11111 → the IR bits shifted out equal 5'b00001.
  - Then shift DR pattern 1,0,1,1 → TDO is 0,1,0,1 (one-bit delay).
- CONFREG write/readback:
  - IR=00110, shift 9'b000000010 (conf value {0,0000,001,0}) through DR → conf_update_o pulses once and conf_reg_o=9'h002.
  - A second DR scan shifting 9'h1FF → first 9 TDO bits equal 9'h002, and conf_reg_o becomes 9'h1FF.
- trst_ni low for 4 cycles during a CONFREG ShDR → state=F, ir_o=00001, conf_reg_o unchanged, conf_update_o stays 0.
- Pause: a CONFREG shift interrupted by PauseDR for 10 TCKs and then resumed → same conf_reg_o result as an uninterrupted shift.
